// File: rtl/blink_sequencer.sv
// blink_sequencer: drives the speed input and active-low reset of an LED blink counter.
// Under start/stop control it ramps the speed (mode 00: up/down loop, mode 01: up then hold) or
// tracks a fixed request (mode 1x). The emitted speed is never 0. The counter is held in reset for
// one cycle on every speed change, so its count can never already be past the new terminal value.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   start        1-cycle pulse, begin a sequence (ignored while busy or with stop)
//   stop         1-cycle pulse, abort the sequence (wins over start and over a step)
//   mode[1:0]    00 ramp up/down loop, 01 ramp up then hold, 1x fixed
//   fixed_speed  requested speed in fixed mode, clamped to MIN_SPEED..MAX_SPEED
//   speed        to counter speed input, always in MIN_SPEED..MAX_SPEED
//   cnt_rst_n    to counter rst_n, low outside DWELL
//   busy         high when not idle
//   step_pulse   1-cycle pulse on each speed change after the first load
//   loops        completed up/down ramps, saturating at 255
module blink_sequencer #(
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter int unsigned MIN_SPEED    = 1,
  parameter int unsigned MAX_SPEED    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [3:0] fixed_speed,
  output logic [3:0] speed,
  output logic       cnt_rst_n,
  output logic       busy,
  output logic       step_pulse,
  output logic [7:0] loops
);

  localparam int unsigned     TimerW    = $clog2(DWELL_CYCLES + 1);
  localparam logic [3:0]      MinSpd    = 4'(MIN_SPEED);
  localparam logic [3:0]      MaxSpd    = 4'(MAX_SPEED);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDwell} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        speed_q, speed_d;
  logic              dir_down_q, dir_down_d;
  logic [7:0]        loops_q, loops_d;
  logic [1:0]        mode_q, mode_d;
  logic              cnt_rst_n_q, cnt_rst_n_d;
  logic              busy_q, busy_d;
  logic              step_pulse_q, step_pulse_d;

  // Candidate values for the next dwell step, applied only when the speed actually changes
  logic [3:0]        nxt_speed;
  logic              nxt_dir_down;
  logic [7:0]        nxt_loops;

  function automatic logic [3:0] clamp_speed(input logic [3:0] x);
    if (x < MinSpd) return MinSpd;
    if (x > MaxSpd) return MaxSpd;
    return x;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    speed_d      = speed_q;
    dir_down_d   = dir_down_q;
    loops_d      = loops_q;
    mode_d       = mode_q;
    nxt_speed    = speed_q;
    nxt_dir_down = dir_down_q;
    nxt_loops    = loops_q;

    // Direction flips on the step that lands on an end value, so each end speed is held
    // for one dwell only.
    if (mode_q[1]) begin
      nxt_speed = clamp_speed(fixed_speed);
    end else if (mode_q[0]) begin
      if (speed_q < MaxSpd) nxt_speed = speed_q + 4'd1;
    end else if (!dir_down_q) begin
      if (speed_q < MaxSpd) begin
        nxt_speed    = speed_q + 4'd1;
        nxt_dir_down = ((speed_q + 4'd1) == MaxSpd);
      end
    end else begin
      if (speed_q > MinSpd) begin
        nxt_speed = speed_q - 4'd1;
        if ((speed_q - 4'd1) == MinSpd) begin
          nxt_dir_down = 1'b0;
          if (loops_q != 8'hFF) nxt_loops = loops_q + 8'd1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          mode_d     = mode;
          speed_d    = mode[1] ? clamp_speed(fixed_speed) : MinSpd;
          dir_down_d = 1'b0;
          timer_d    = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        timer_d = '0;
        state_d = StDwell;
      end
      StDwell: begin
        if (timer_q == TimerLast) begin
          timer_d = '0;
          if (nxt_speed != speed_q) begin
            speed_d    = nxt_speed;
            dir_down_d = nxt_dir_down;
            loops_d    = nxt_loops;
            state_d    = StLoad;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any step taken this cycle; loops is kept.
    if (stop && (state_q != StIdle)) begin
      state_d    = StIdle;
      speed_d    = MinSpd;
      dir_down_d = 1'b0;
      timer_d    = '0;
      loops_d    = loops_q;
    end
  end

  // Output decode, computed from the next state so the outputs come straight from flops
  always_comb begin
    cnt_rst_n_d  = (state_d == StDwell);
    busy_d       = (state_d != StIdle);
    step_pulse_d = (state_q == StDwell) && (state_d == StLoad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q      <= '0;
      speed_q      <= MinSpd;
      dir_down_q   <= 1'b0;
      loops_q      <= 8'd0;
      mode_q       <= 2'b00;
      cnt_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      speed_q      <= speed_d;
      dir_down_q   <= dir_down_d;
      loops_q      <= loops_d;
      mode_q       <= mode_d;
      cnt_rst_n_q  <= cnt_rst_n_d;
      busy_q       <= busy_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign speed      = speed_q;
  assign cnt_rst_n  = cnt_rst_n_q;
  assign busy       = busy_q;
  assign step_pulse = step_pulse_q;
  assign loops      = loops_q;

endmodule
